// File: rtl/rf_wport_arb.sv
// Register-file write-port arbiter: write-back stage vs. buffered long-latency results.
// Write-back normally wins; a starving buffered result raises ws_hold and is forced through.
module rf_wport_arb #(
   parameter int unsigned STARVE_MAX = 4,
   parameter int unsigned DEPTH      = 2
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        ws_we,
   input  logic [4:0]  ws_waddr,
   input  logic [31:0] ws_wdata,
   output logic        ws_hold,
   input  logic        ll_valid,
   output logic        ll_ready,
   input  logic [4:0]  ll_waddr,
   input  logic [31:0] ll_wdata,
   input  logic        flush,
   output logic        rf_we,
   output logic [4:0]  rf_waddr,
   output logic [31:0] rf_wdata,
   output logic [31:0] pend_mask
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam int unsigned STV_W = 4;

   logic [4:0]       addr_q [DEPTH];
   logic [4:0]       addr_d [DEPTH];
   logic [31:0]      data_q [DEPTH];
   logic [31:0]      data_d [DEPTH];
   logic [PTR_W-1:0] head_q, head_d;
   logic [PTR_W-1:0] tail_q, tail_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [STV_W-1:0] starve_q, starve_d;

   logic             nonempty;
   logic             full;
   logic             ws_req;
   logic             ws_gnt;
   logic             fifo_gnt;
   logic             pop;
   logic             push;
   logic [PTR_W-1:0] idx;

   // Status flags depend on registered state only, so ws_hold/ll_ready have no input paths.
   always_comb begin
      nonempty = (count_q != '0);
      full     = (count_q == CNT_W'(DEPTH));
      ll_ready = !full;
      ws_hold  = nonempty && (starve_q == STV_W'(STARVE_MAX));
   end

   always_comb begin
      ws_req   = ws_we && (ws_waddr != 5'd0);
      ws_gnt   = !ws_hold && ws_req;
      fifo_gnt = ws_hold || (!ws_req && nonempty);
      pop      = fifo_gnt && !flush;
      // Writes to r0 are consumed by the handshake but never stored.
      push     = ll_valid && ll_ready && !flush && (ll_waddr != 5'd0);
   end

   always_comb begin
      rf_we    = 1'b0;
      rf_waddr = '0;
      rf_wdata = '0;
      if (resetn) begin
         if (ws_gnt) begin
            rf_we    = 1'b1;
            rf_waddr = ws_waddr;
            rf_wdata = ws_wdata;
         end else if (fifo_gnt && !flush) begin
            rf_we    = 1'b1;
            rf_waddr = addr_q[head_q];
            rf_wdata = data_q[head_q];
         end
      end
   end

   always_comb begin
      addr_d   = addr_q;
      data_d   = data_q;
      head_d   = head_q;
      tail_d   = tail_q;
      count_d  = count_q;
      starve_d = starve_q;
      if (flush) begin
         head_d   = '0;
         tail_d   = '0;
         count_d  = '0;
         starve_d = '0;
      end else begin
         if (push) begin
            addr_d[tail_q] = ll_waddr;
            data_d[tail_q] = ll_wdata;
            tail_d         = tail_q + PTR_W'(1);
         end
         if (pop) begin
            head_d = head_q + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
         if (!nonempty || pop) begin
            starve_d = '0;
         end else if (starve_q != STV_W'(STARVE_MAX)) begin
            starve_d = starve_q + STV_W'(1);
         end
      end
   end

   // Head stays in the mask during the cycle it is written to the register file.
   always_comb begin
      pend_mask = '0;
      idx       = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         idx = head_q + PTR_W'(i);
         if (CNT_W'(i) < count_q) begin
            pend_mask[addr_q[idx]] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         head_q   <= '0;
         tail_q   <= '0;
         count_q  <= '0;
         starve_q <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            addr_q[i] <= '0;
            data_q[i] <= '0;
         end
      end else begin
         head_q   <= head_d;
         tail_q   <= tail_d;
         count_q  <= count_d;
         starve_q <= starve_d;
         addr_q   <= addr_d;
         data_q   <= data_d;
      end
   end

endmodule
